// File: rtl/memory_access_stage_pkg.sv
// Shared types for the MEM stage: opcodes, access sizes, FSM states and the control bundle.
// Pure declarations; no latency or flow-control behaviour of its own.
package memory_access_stage_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_state_e;

    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  dest_reg;
        logic [2:0]  funct3;
        logic [6:0]  opcode;
    } control_signals_struct;

    function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return off[0];
            SIZE_W:  return |off[1:0];
            default: return |off;
        endcase
    endfunction

    function automatic logic [7:0] size_strb(input logic [1:0] size);
        case (size)
            SIZE_B:  return 8'h01;
            SIZE_H:  return 8'h03;
            SIZE_W:  return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/memory_access_stage_if.sv
// Data-cache request/response port; master = MEM stage, slave = cache.
// Request side is valid/ready; response side is valid-only (the stage always sinks it).
interface memory_access_stage_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic                  dcache_req_valid;
    logic                  dcache_req_ready;
    logic [ADDR_W-1:0]     dcache_req_addr;
    logic                  dcache_req_write;
    logic [DATA_W-1:0]     dcache_req_wdata;
    logic [DATA_W/8-1:0]   dcache_req_strb;
    logic                  dcache_resp_valid;
    logic [DATA_W-1:0]     dcache_resp_data;

    modport master (
        output dcache_req_valid, dcache_req_addr, dcache_req_write,
               dcache_req_wdata, dcache_req_strb,
        input  dcache_req_ready, dcache_resp_valid, dcache_resp_data
    );

    modport slave (
        input  dcache_req_valid, dcache_req_addr, dcache_req_write,
               dcache_req_wdata, dcache_req_strb,
        output dcache_req_ready, dcache_resp_valid, dcache_resp_data
    );
endinterface

// File: rtl/memory_access_stage_load_data_extender.sv
// Selects the addressed bytes of a cache doubleword and sign/zero-extends them by funct3.
// Combinational, no backpressure.
module load_data_extender (
    input  logic [63:0] resp_data,
    input  logic [2:0]  offset,
    input  logic [2:0]  funct3,
    output logic [63:0] ext_data
);
    logic [63:0] lane;

    always_comb begin
        lane     = resp_data >> {offset, 3'b000};
        ext_data = '0;
        case (funct3)
            3'b000:  ext_data = {{56{lane[7]}},  lane[7:0]};
            3'b001:  ext_data = {{48{lane[15]}}, lane[15:0]};
            3'b010:  ext_data = {{32{lane[31]}}, lane[31:0]};
            3'b011:  ext_data = lane;
            3'b100:  ext_data = {56'b0, lane[7:0]};
            3'b101:  ext_data = {48'b0, lane[15:0]};
            3'b110:  ext_data = {32'b0, lane[31:0]};
            default: ext_data = '0;
        endcase
    end
endmodule

// File: rtl/memory_access_stage.sv
// RV64 MEM stage: non-memory ops retire 1 cycle after acceptance; loads/stores go through the dcache port.
// mem_ready drops while a cache access is outstanding; requests hold stable until dcache_req_ready.
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_module_enable,
    output logic                   mem_ready,
    input  logic [ADDR_W-1:0]      alu_result,
    input  logic [DATA_W-1:0]      store_data,
    input  control_signals_struct  control_signals,
    memory_access_stage_if.master  dcache,
    output logic [ADDR_W-1:0]      wb_alu_result,
    output logic [DATA_W-1:0]      wb_loaded_data,
    output control_signals_struct  wb_control_signals,
    output logic                   wb_module_enable,
    output logic                   misaligned_fault
);
    mem_state_e            state_q, state_d;
    logic [ADDR_W-1:0]     alu_q, alu_d;
    logic [DATA_W-1:0]     sdata_q, sdata_d;
    control_signals_struct ctrl_q, ctrl_d;
    logic [ADDR_W-1:0]     wb_alu_q, wb_alu_d;
    logic [DATA_W-1:0]     wb_load_q, wb_load_d;
    control_signals_struct wb_ctrl_q, wb_ctrl_d;
    logic                  fault_q, fault_d;

    logic                  accept, in_mem, in_mis, req_active, store_q;
    logic [DATA_W-1:0]     ext_data;

    load_data_extender u_ext (
        .resp_data (dcache.dcache_resp_data),
        .offset    (alu_q[2:0]),
        .funct3    (ctrl_q.funct3),
        .ext_data  (ext_data)
    );

    assign mem_ready = !reset && (state_q == IDLE || state_q == DONE);
    assign accept    = mem_module_enable && mem_ready;
    assign in_mem    = (control_signals.opcode == OPC_LOAD) || (control_signals.opcode == OPC_STORE);
    assign in_mis    = in_mem && is_misaligned(alu_result[2:0], control_signals.funct3[1:0]);

    always_comb begin
        state_d   = state_q;
        alu_d     = alu_q;
        sdata_d   = sdata_q;
        ctrl_d    = ctrl_q;
        wb_alu_d  = wb_alu_q;
        wb_load_d = wb_load_q;
        wb_ctrl_d = wb_ctrl_q;
        fault_d   = fault_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    alu_d   = alu_result;
                    sdata_d = store_data;
                    ctrl_d  = control_signals;
                    if (in_mem && !in_mis) begin
                        state_d = REQ;
                    end else begin
                        // Non-memory and faulting accesses complete straight from the inputs.
                        state_d   = DONE;
                        wb_alu_d  = alu_result;
                        wb_ctrl_d = control_signals;
                        wb_load_d = (control_signals.opcode == OPC_LUI) ? alu_result : '0;
                        fault_d   = in_mis;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (dcache.dcache_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (dcache.dcache_resp_valid) begin
                    state_d   = DONE;
                    wb_alu_d  = alu_q;
                    wb_ctrl_d = ctrl_q;
                    wb_load_d = (ctrl_q.opcode == OPC_LOAD) ? ext_data : '0;
                    fault_d   = (ctrl_q.opcode == OPC_LOAD) && (ctrl_q.funct3 == 3'b111);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            alu_q     <= '0;
            sdata_q   <= '0;
            ctrl_q    <= '0;
            wb_alu_q  <= '0;
            wb_load_q <= '0;
            wb_ctrl_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_q     <= alu_d;
            sdata_q   <= sdata_d;
            ctrl_q    <= ctrl_d;
            wb_alu_q  <= wb_alu_d;
            wb_load_q <= wb_load_d;
            wb_ctrl_q <= wb_ctrl_d;
            fault_q   <= fault_d;
        end
    end

    assign req_active = !reset && (state_q == REQ);
    assign store_q    = ctrl_q.opcode == OPC_STORE;

    assign dcache.dcache_req_valid = req_active;
    assign dcache.dcache_req_addr  = req_active ? {alu_q[ADDR_W-1:3], 3'b000} : '0;
    assign dcache.dcache_req_write = req_active && store_q;
    assign dcache.dcache_req_wdata = (req_active && store_q) ? (sdata_q << {alu_q[2:0], 3'b000}) : '0;
    assign dcache.dcache_req_strb  = (req_active && store_q) ? (size_strb(ctrl_q.funct3[1:0]) << alu_q[2:0]) : '0;

    assign wb_alu_result      = wb_alu_q;
    assign wb_loaded_data     = wb_load_q;
    assign wb_control_signals = wb_ctrl_q;
    assign wb_module_enable   = !reset && (state_q == DONE);
    assign misaligned_fault   = !reset && (state_q == DONE) && fault_q;
endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage with a queue-based retirement model.
module tb_memory_access_stage;
    import memory_access_stage_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  mem_module_enable;
    logic                  mem_ready;
    logic [63:0]           alu_result;
    logic [63:0]           store_data;
    control_signals_struct control_signals;
    logic [63:0]           wb_alu_result;
    logic [63:0]           wb_loaded_data;
    control_signals_struct wb_control_signals;
    logic                  wb_module_enable;
    logic                  misaligned_fault;

    memory_access_stage_if #(.ADDR_W(64), .DATA_W(64)) dc ();

    memory_access_stage #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk                (clk),
        .reset              (reset),
        .mem_module_enable  (mem_module_enable),
        .mem_ready          (mem_ready),
        .alu_result         (alu_result),
        .store_data         (store_data),
        .control_signals    (control_signals),
        .dcache             (dc),
        .wb_alu_result      (wb_alu_result),
        .wb_loaded_data     (wb_loaded_data),
        .wb_control_signals (wb_control_signals),
        .wb_module_enable   (wb_module_enable),
        .misaligned_fault   (misaligned_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] alu;
        logic [63:0] loaded;
        logic        fault;
        logic [4:0]  dest;
        logic [63:0] pc;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   tag = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // What write-back must see, from the ISA rules alone.
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [63:0] alu, input logic [63:0] word, input int t);
        exp_t r;
        int size, off;
        logic [63:0] mask, v;
        size = 1 << f3[1:0];
        off  = int'(alu[2:0]);
        mask = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * size)) - 64'd1);
        r.alu = alu; r.loaded = '0; r.fault = 1'b0;
        r.dest = 5'(t); r.pc = 64'h8000_0000 + 64'(4 * t);
        if (op == OPC_LOAD || op == OPC_STORE) begin
            if (off % size != 0) r.fault = 1'b1;
            else if (op == OPC_LOAD) begin
                if (f3 == 3'b111) r.fault = 1'b1;
                else begin
                    v = (word >> (8 * off)) & mask;
                    if (!f3[2] && size < 8 && v[8 * size - 1]) v = v | ~mask;
                    r.loaded = v;
                end
            end
        end else if (op == OPC_LUI) r.loaded = alu;
        return r;
    endfunction

    task automatic store_fmt(input logic [63:0] sdata, input logic [2:0] f3, input logic [63:0] alu,
                             output logic [63:0] wdata, output logic [7:0] strb);
        int size, off;
        size  = 1 << f3[1:0];
        off   = int'(alu[2:0]);
        wdata = sdata << (8 * off);
        strb  = 8'(((1 << size) - 1) << off);
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] alu,
                         input logic [63:0] sdata);
        tag++;
        alu_result               = alu;
        store_data               = sdata;
        control_signals.opcode   = op;
        control_signals.funct3   = f3;
        control_signals.dest_reg = 5'(tag);
        control_signals.pc       = 64'h8000_0000 + 64'(4 * tag);
        mem_module_enable        = 1'b1;
    endtask

    // Called at posedge+1 with the stage idle; returns at posedge+1 with the stage idle again.
    task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] alu,
                          input logic [63:0] sdata, input logic [63:0] word, input int rdly, input int sdly);
        logic [63:0] ewdata;
        logic [7:0]  estrb;
        bit          to_cache;
        to_cache = (op == OPC_LOAD || op == OPC_STORE) && (int'(alu[2:0]) % (1 << f3[1:0]) == 0);
        store_fmt(sdata, f3, alu, ewdata, estrb);
        drive(op, f3, alu, sdata);
        check("accept_ready", mem_ready, 1'b1);
        expq.push_back(model(op, f3, alu, word, tag));
        @(posedge clk); #1;
        mem_module_enable = 1'b0;
        if (to_cache) begin
            for (int i = 0; i <= rdly; i++) begin
                dc.dcache_req_ready  = (i == rdly);
                dc.dcache_resp_valid = (i < rdly);
                dc.dcache_resp_data  = ~word;
                check("req_valid", dc.dcache_req_valid, 1'b1);
                check("req_addr", dc.dcache_req_addr, alu & ~64'h7);
                check("req_write", dc.dcache_req_write, op == OPC_STORE);
                if (op == OPC_STORE) begin
                    check("req_wdata", dc.dcache_req_wdata, ewdata);
                    check("req_strb", dc.dcache_req_strb, estrb);
                end
                @(posedge clk); #1;
            end
            dc.dcache_req_ready  = 1'b0;
            dc.dcache_resp_valid = 1'b0;
            for (int i = 0; i < sdly; i++) begin
                check("early_retire", wb_module_enable, 1'b0);
                check("req_dropped", dc.dcache_req_valid, 1'b0);
                @(posedge clk); #1;
            end
            dc.dcache_resp_valid = 1'b1;
            dc.dcache_resp_data  = word;
            @(posedge clk); #1;
            dc.dcache_resp_valid = 1'b0;
        end else begin
            check("no_cache_req", dc.dcache_req_valid, 1'b0);
        end
        @(posedge clk); #1;
    endtask

    // Compare process: every retirement pulse must match the head of the model queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && wb_module_enable) begin
                if (expq.size() == 0) check("unexpected_retire", wb_module_enable, 1'b0);
                else begin
                    e = expq.pop_front();
                    check("wb_alu_result", wb_alu_result, e.alu);
                    check("wb_loaded_data", wb_loaded_data, e.loaded);
                    check("misaligned_fault", misaligned_fault, e.fault);
                    check("wb_dest_reg", wb_control_signals.dest_reg, e.dest);
                    check("wb_pc", wb_control_signals.pc, e.pc);
                end
            end else if (!reset) begin
                check("fault_without_retire", misaligned_fault, 1'b0);
            end
        end
    end

    initial begin
        exp_t        p;
        logic [63:0] pw;
        logic [7:0]  ps;
        reset = 1'b1;
        mem_module_enable = 1'b0;
        alu_result = '0; store_data = '0; control_signals = '0;
        dc.dcache_req_ready = 1'b0; dc.dcache_resp_valid = 1'b0; dc.dcache_resp_data = '0;

        // Pin the model to hand-computed values.
        p = model(OPC_LOAD, 3'b000, 64'h1003, 64'h0000_0000_8000_0000, 0);
        check("pin_lb", p.loaded, 64'hFFFF_FFFF_FFFF_FF80);
        p = model(OPC_LOAD, 3'b100, 64'h1003, 64'h0000_0000_8000_0000, 0);
        check("pin_lbu", p.loaded, 64'h80);
        p = model(OPC_LOAD, 3'b010, 64'h3002, 64'h0, 0);
        check("pin_lw_fault", {63'b0, p.fault}, 64'h1);
        p = model(OPC_LUI, 3'b000, 64'h1234_5000, 64'h0, 0);
        check("pin_lui", p.loaded, 64'h1234_5000);
        store_fmt(64'hABCD, 3'b001, 64'h2006, pw, ps);
        check("pin_sh_wdata", pw, 64'hABCD_0000_0000_0000);
        check("pin_sh_strb", ps, 8'hC0);

        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_ready", mem_ready, 1'b0);
        check("rst_wb_en", wb_module_enable, 1'b0);
        check("rst_req_valid", dc.dcache_req_valid, 1'b0);
        check("rst_wb_alu", wb_alu_result, 64'h0);
        check("rst_fault", misaligned_fault, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", mem_ready, 1'b1);

        run_op(OPC_OP, 3'b000, 64'h55, 64'h0, 64'h0, 0, 0);

        // Back-to-back ADDs: one accepted and retired per cycle.
        for (int i = 0; i < 3; i++) begin
            drive(OPC_OP, 3'b000, 64'h100 + 64'(i), 64'h0);
            check("b2b_ready", mem_ready, 1'b1);
            expq.push_back(model(OPC_OP, 3'b000, 64'h100 + 64'(i), 64'h0, tag));
            @(posedge clk); #1;
        end
        mem_module_enable = 1'b0;
        @(posedge clk); #1;
        check("b2b_drained", 64'(expq.size()), 64'h0);

        run_op(OPC_LOAD,   3'b000, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 2, 1);
        run_op(OPC_LOAD,   3'b100, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 0);
        run_op(OPC_STORE,  3'b001, 64'h2006, 64'hABCD, 64'h0, 1, 2);
        run_op(OPC_LOAD,   3'b010, 64'h3002, 64'h0, 64'h0, 0, 0);
        run_op(OPC_LUI,    3'b000, 64'h1234_5000, 64'h0, 64'h0, 0, 0);
        run_op(OPC_LOAD,   3'b011, 64'h4008, 64'h0, 64'h1122_3344_5566_7788, 1, 0);
        run_op(OPC_LOAD,   3'b101, 64'h5006, 64'h0, 64'hBEEF_0000_0000_0000, 0, 1);
        run_op(OPC_LOAD,   3'b110, 64'h6004, 64'h0, 64'h8000_0001_0000_0000, 0, 0);
        run_op(OPC_LOAD,   3'b010, 64'h6004, 64'h0, 64'h8000_0001_0000_0000, 0, 0);
        run_op(OPC_STORE,  3'b000, 64'h7005, 64'h5A, 64'h0, 0, 0);
        run_op(OPC_STORE,  3'b011, 64'h7000, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0);
        run_op(OPC_LOAD,   3'b111, 64'h7008, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
        run_op(OPC_STORE,  3'b010, 64'h7006, 64'h1, 64'h0, 0, 0);
        run_op(OPC_BRANCH, 3'b001, 64'h9999, 64'h0, 64'h0, 0, 0);

        // Reset while waiting for a load response; the late response must be dropped.
        drive(OPC_LOAD, 3'b011, 64'h8000, 64'h0);
        @(posedge clk); #1;
        mem_module_enable = 1'b0;
        dc.dcache_req_ready = 1'b1;
        @(posedge clk); #1;
        dc.dcache_req_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_mem_ready", mem_ready, 1'b0);
        check("midrst_wb_en", wb_module_enable, 1'b0);
        check("midrst_req_valid", dc.dcache_req_valid, 1'b0);
        check("midrst_wb_alu", wb_alu_result, 64'h0);
        check("midrst_wb_loaded", wb_loaded_data, 64'h0);
        reset = 1'b0;
        dc.dcache_resp_valid = 1'b1;
        dc.dcache_resp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clk); #1;
        dc.dcache_resp_valid = 1'b0;
        check("late_resp_ignored", wb_module_enable, 1'b0);
        check("ready_after_midrst", mem_ready, 1'b1);
        run_op(OPC_LOAD, 3'b011, 64'h8000, 64'h0, 64'hCAFE_F00D_1234_5678, 1, 1);

        repeat (3) @(posedge clk);
        #1;
        check("pending_retirements", 64'(expq.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
